fifo_skew_reader: RTL and testbench
===================================

# fifo_skew_reader

Read-side sequencer for the per-row input FIFO array that feeds the CNN systolic array. On `start`, it drains `row_len` words from each of `array_size` FIFOs with a diagonal skew: lane i starts i cycles after lane 0. Each lane's output is tagged with a valid bit. The write side loads the FIFOs independently; this block owns every `r_en` and presents skewed row data to the PE array's west edge.

## Interface
Parameters:
- `array_size`, 9: number of FIFO lanes and PE rows.
- `data_size`, 8: word width per lane.
- `row_len`, 9: words read from each lane per tile (≥1).
- `step_w`, 5: width of the step counter; must satisfy 2^step_w > row_len+array_size-1.

Ports:
- `clk` in 1: single clock. Also drives FIFO reads.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin one tile. Sampled only in IDLE.
- `abort` in 1: synchronous abort to IDLE.
- `fifo_empty` in `array_size`: per-lane FIFO empty flags.
- `fifo_data` in `data_size*array_size`: per-lane FIFO read data. Lane i occupies bits [(i+1)*data_size-1 : i*data_size].
- `r_en` out `array_size`: per-lane FIFO read enable. Combinational.
- `data_out` out `data_size*array_size`: skewed lane data to PE rows. Same lane packing as `fifo_data`.
- `valid_out` out `array_size`: lane i `data_out` is valid this cycle.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of tile.

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`; `step` is cleared to 0.
  - RUN→DRAIN after an unstalled cycle with `step` = S-1, where S = row_len+array_size-1.
  - DRAIN→IDLE unconditionally after one cycle.
- **Lane activity:** lane i is active when i ≤ `step` < i+row_len, computed at full width with no wrap.
- **Stall:** `stall` = RUN & OR over active lanes of `fifo_empty[i]`. Empty flags on inactive lanes are ignored.
  - During a stall, all `r_en` = 0 and `step` holds. Lanes advance in lockstep only, so skew is never broken.
- **Read enable:** `r_en[i]` = RUN & active_i & ~stall.
- **Step counter:** `step` increments on every RUN cycle without a stall.
- **Valid:** `valid_out` is `r_en` registered one cycle, matching the FIFO's 1-cycle read latency.
- **Data:** `data_out` lane i is taken from `fifo_data` lane i in cycles where `valid_out[i]` = 1.
- **Done:** `done` = 1 in the DRAIN cycle, which carries the final valid word of lane array_size-1.
- **Start while busy:** ignored, with no queueing.
- **Abort:** from any state, abort takes priority over every other transition. Next cycle: state IDLE, `step` 0, `valid_out` 0, no `done` pulse. Words already popped are lost; the writer is responsible for clearing the FIFOs.
- **Reset values:** `r_en` 0, `valid_out` 0, `data_out` 0, `busy` 0, `done` 0, state IDLE, `step` 0.

## Timing
- With `start` sampled high at edge 0, RUN spans cycles 1..S when there are no stalls.
  - Lane 0 `r_en` is high in cycles 1..row_len.
  - Lane i `r_en` is high in cycles 1+i..row_len+i.
- `valid_out[i]` is high exactly one cycle after the corresponding `r_en[i]`.
- DRAIN is cycle S+1. `done` and the last `valid_out[array_size-1]` are both high in that cycle. IDLE is reached at cycle S+2.
- Each stalled cycle extends RUN by one cycle. It also inserts one all-zero `valid_out` cycle, one cycle later.
- Minimum gap between tiles: `start` may be accepted in the first IDLE cycle after DRAIN. Tile period is S+2 cycles.
- Reset asserted mid-tile drives all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- **`FIFO_SKEW_ZERO_PAD_EN` defined:** `data_out` lane i is forced to 0 in any cycle where `valid_out[i]` = 0. This gives the PE array implicit zero padding at the skew triangle edges.
- **Not defined:** each `data_out` lane register loads only when its valid bit is set and otherwise holds its last loaded value. Consumers must qualify data with `valid_out`.

## Test plan
- **Basic skewed drain.** array_size=3, row_len=4. Lane i is preloaded with words 0x10*i+0..3; `start` at cycle 0.
  - Lane 0 `r_en` is high in cycles 1–4 and lane 2 in cycles 3–6.
  - `valid_out[2]` is high in cycles 4–7 with data 0x20..0x23.
  - `done` pulses at cycle 7.
- **Mid-tile stall.** Lane 1 `fifo_empty` is forced high in cycle 3 (lane 1 active).
  - All `r_en` are low in cycle 3 and `step` holds.
  - `valid_out` is all-zero in cycle 4.
  - `done` moves from cycle 7 to cycle 8, and data order is unchanged.
- **Inactive-lane empty ignored.** Lane 2 `fifo_empty` is high in cycles 1–2 (before lane 2 activates).
  - No stall occurs; timing matches the basic drain test exactly.
- **Abort and start-while-busy.** `start` is pulsed again at cycle 3, then `abort` at cycle 4.
  - The second `start` is ignored.
  - `busy` = 0 and `valid_out` = 0 from cycle 5 onward, with no `done`.
  - A new `start` at cycle 6 runs a full tile.
- **Async reset mid-RUN.** `rst_n` goes low between edges in cycle 3.
  - All outputs go to 0 before the next edge.
  - After release, `start` produces a normal tile.
- **Zero-pad macro.** Compile with and without `FIFO_SKEW_ZERO_PAD_EN` and check lane 2 in cycles 1–3.
  - Defined: `data_out` lane 2 = 0x00.
  - Not defined: lane 2 holds 0x00 after reset, then the last valid word after a prior tile.

Source files
------------

// File: rtl/fifo_skew_reader_if.sv
// Bus bundle between the skew reader, the per-row FIFO read ports and the PE west edge.
// master = reader side, slave = FIFO/PE/environment side.
interface fifo_skew_reader_if #(
  parameter int array_size = 9,
  parameter int data_size  = 8
);
  logic                            start;
  logic                            abort;
  logic [array_size-1:0]           fifo_empty;
  logic [data_size*array_size-1:0] fifo_data;
  logic [array_size-1:0]           r_en;
  logic [data_size*array_size-1:0] data_out;
  logic [array_size-1:0]           valid_out;
  logic                            busy;
  logic                            done;

  modport master (
    input  start, abort, fifo_empty, fifo_data,
    output r_en, data_out, valid_out, busy, done
  );

  modport slave (
    output start, abort, fifo_empty, fifo_data,
    input  r_en, data_out, valid_out, busy, done
  );
endinterface

// File: rtl/fifo_skew_reader.sv
// Diagonal-skew read sequencer for the systolic-array row FIFOs; lane i lags lane 0 by i cycles.
// Optional macro FIFO_SKEW_ZERO_PAD_EN zeroes data_out lanes whose valid bit is low.
module fifo_skew_reader #(
  parameter int array_size = 9,
  parameter int data_size  = 8,
  parameter int row_len    = 9,
  parameter int step_w     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_skew_reader_if.master     skew_if
);

  localparam int                S_STEPS   = row_len + array_size - 1;
  localparam logic [step_w-1:0] LAST_STEP = step_w'(S_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [step_w-1:0]               step_q, step_d;
  logic [array_size-1:0]           valid_q, valid_d;
  logic [data_size*array_size-1:0] data_q, data_d;
  logic [array_size-1:0]           active;
  logic [array_size-1:0]           r_en;
  logic                            run;
  logic                            stall;
  int                              step_int;

  // Lane window compared as int so i+row_len can never wrap the step width.
  always_comb begin
    active   = '0;
    step_int = int'(step_q);
    for (int i = 0; i < array_size; i++) begin
      active[i] = (step_int >= i) && (step_int < i + row_len);
    end
  end

  assign run   = (state_q == ST_RUN);
  assign stall = run && ((active & skew_if.fifo_empty) != '0);
  assign r_en  = (run && !stall) ? active : '0;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (skew_if.abort) begin
      state_d = ST_IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (skew_if.start) begin
            state_d = ST_RUN;
            step_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            step_d = step_q + step_w'(1'b1);
            if (step_q == LAST_STEP) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            step_d = step_q;
          end
        end
        ST_DRAIN: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  // fifo_data is the head word at the r_en edge, so data lands in step with valid_out.
  always_comb begin
    valid_d = skew_if.abort ? '0 : r_en;
    data_d  = data_q;
    for (int i = 0; i < array_size; i++) begin
      if (valid_d[i]) begin
        data_d[i*data_size +: data_size] = skew_if.fifo_data[i*data_size +: data_size];
      end else begin
`ifdef FIFO_SKEW_ZERO_PAD_EN
        data_d[i*data_size +: data_size] = '0;
`else
        data_d[i*data_size +: data_size] = data_q[i*data_size +: data_size];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign skew_if.r_en      = r_en;
  assign skew_if.valid_out = valid_q;
  assign skew_if.data_out  = data_q;
  assign skew_if.busy      = (state_q != ST_IDLE);
  assign skew_if.done      = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Scoreboard bench for fifo_skew_reader (array_size=3, row_len=4): directed tiles, stall,
// inactive-lane empty, abort, async reset, back-to-back start and lane-2 hold/zero-pad data.
module tb_fifo_skew_reader;
  localparam int AS = 3;
  localparam int DS = 8;
  localparam int RL = 4;
  localparam int SW = 3;

  // Expected per-offset values (offset 0 = cycle start is high), no stall.
  localparam logic [2:0] REN_B [0:8] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
  localparam logic [2:0] VLD_B [0:8] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
  localparam logic [8:0] BSY_B = 9'b0_1111_1110;
  localparam logic [8:0] DON_B = 9'b0_1000_0000;
  // Same tile with one stall at offset 3.
  localparam logic [2:0] REN_S [0:9] = '{3'b000, 3'b001, 3'b011, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
  localparam logic [2:0] VLD_S [0:9] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
  localparam logic [9:0] BSY_S = 10'b01_1111_1110;
  localparam logic [9:0] DON_S = 10'b01_0000_0000;

  typedef struct {
    int          cyc;
    logic [2:0]  ren;
    logic [2:0]  vld;
    logic        busy;
    logic        done;
    logic [2:0]  dmask;
    logic [23:0] dexp;
  } rec_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  logic end_req = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [AS-1:0] force_e;

  rec_t          exp_q [$];
  logic [DS-1:0] exp_d [AS][$];
  logic [DS-1:0] fq [AS][$];

  fifo_skew_reader_if #(.array_size(AS), .data_size(DS)) bus ();

  fifo_skew_reader #(.array_size(AS), .data_size(DS), .row_len(RL), .step_w(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .skew_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  initial begin : monitor
    rec_t          r;
    logic [DS-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk === 1'b1) begin
        #1;
        check("async_rst_r_en", 32'(bus.r_en), 32'h0);
        check("async_rst_valid", 32'(bus.valid_out), 32'h0);
        check("async_rst_data", 32'(bus.data_out), 32'h0);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        check("async_rst_done", 32'(bus.done), 32'h0);
        exp_q.delete();
        for (int i = 0; i < AS; i++) exp_d[i].delete();
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          r = exp_q.pop_front();
          if (r.cyc < cyc) begin
            check("stale_record", 32'(cyc), 32'(r.cyc));
          end else begin
            check("r_en", 32'(bus.r_en), 32'(r.ren));
            check("valid_out", 32'(bus.valid_out), 32'(r.vld));
            check("busy", 32'(bus.busy), 32'(r.busy));
            check("done", 32'(bus.done), 32'(r.done));
            for (int i = 0; i < AS; i++) begin
              if (r.dmask[i]) check("data_idle_lane", 32'(bus.data_out[i*DS +: DS]), 32'(r.dexp[i*DS +: DS]));
            end
          end
        end
        for (int i = 0; i < AS; i++) begin
          if (bus.valid_out[i] === 1'b1) begin
            if (exp_d[i].size() == 0) begin
              check("unexpected_valid_lane", 32'(i), 32'hFFFF_FFFF);
            end else begin
              e = exp_d[i].pop_front();
              check("data_lane", 32'(bus.data_out[i*DS +: DS]), 32'(e));
            end
          end
        end
        if (end_req) begin
          check("records_left", 32'(exp_q.size()), 32'h0);
          for (int i = 0; i < AS; i++) check("data_left", 32'(exp_d[i].size()), 32'h0);
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $finish;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] l2_hold(input logic [7:0] x);
    logic [7:0] v;
    v = x;
`ifdef FIFO_SKEW_ZERO_PAD_EN
    v = 8'h00;
`endif
    return v;
  endfunction

  task automatic drive_fifo();
    for (int i = 0; i < AS; i++) begin
      bus.fifo_data[i*DS +: DS] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
      bus.fifo_empty[i]         = (fq[i].size() == 0) || force_e[i];
    end
  endtask

  task automatic tick();
    logic [AS-1:0] pop;
    @(negedge clk);
    pop = bus.r_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < AS; i++) begin
      if (pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    drive_fifo();
  endtask

  task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int k = 0; k < RL; k++) begin
      fq[0].push_back(b0 + 8'(k));
      fq[1].push_back(b1 + 8'(k));
      fq[2].push_back(b2 + 8'(k));
    end
    drive_fifo();
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < AS; i++) fq[i].delete();
    drive_fifo();
  endtask

  task automatic add_rec(input int c, input logic [2:0] ren, input logic [2:0] vld, input logic bsy,
                         input logic dn, input logic [2:0] msk, input logic [23:0] dx);
    rec_t r;
    r.cyc = c; r.ren = ren; r.vld = vld; r.busy = bsy; r.done = dn; r.dmask = msk; r.dexp = dx;
    exp_q.push_back(r);
  endtask

  task automatic push_tile(input int c0, input bit stall, input logic [7:0] l2,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int n;
    logic [2:0] msk;
    n = stall ? 10 : 9;
    for (int o = 0; o < n; o++) begin
      msk = (o >= 1 && o <= 3) ? 3'b100 : 3'b000;
      if (stall) add_rec(c0 + o, REN_S[o], VLD_S[o], BSY_S[o], DON_S[o], msk, {l2, 16'h0000});
      else       add_rec(c0 + o, REN_B[o], VLD_B[o], BSY_B[o], DON_B[o], msk, {l2, 16'h0000});
    end
    for (int k = 0; k < RL; k++) begin
      exp_d[0].push_back(b0 + 8'(k));
      exp_d[1].push_back(b1 + 8'(k));
      exp_d[2].push_back(b2 + 8'(k));
    end
  endtask

  initial begin : stimulus
    int c0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    force_e = 3'b000;
    drive_fifo();
    @(posedge clk);
    #1;
    add_rec(cyc, 3'b000, 3'b000, 1'b0, 1'b0, 3'b111, 24'h000000);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic tile, then a second tile started in the first IDLE cycle after DRAIN.
    c0 = cyc;
    push_tile(c0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h20);
    load3(8'h00, 8'h10, 8'h20);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (7) tick();

    // Lane 2 empty while still inactive must not stall.
    c0 = cyc;
    push_tile(c0, 1'b0, l2_hold(8'h23), 8'h30, 8'h40, 8'h50);
    load3(8'h30, 8'h40, 8'h50);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    force_e = 3'b100; drive_fifo();
    tick(); tick();
    force_e = 3'b000; drive_fifo();
    repeat (6) tick();
    repeat (2) tick();

    // Active lane 1 empty at offset 3 stalls everything for one cycle.
    c0 = cyc;
    push_tile(c0, 1'b1, l2_hold(8'h53), 8'h60, 8'h70, 8'h80);
    load3(8'h60, 8'h70, 8'h80);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();
    force_e = 3'b010; drive_fifo();
    tick();
    force_e = 3'b000; drive_fifo();
    repeat (6) tick();
    repeat (2) tick();

    // Start while busy at offset 3, abort at offset 4, fresh tile at offset 6.
    c0 = cyc;
    add_rec(c0 + 0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000000);
    add_rec(c0 + 1, 3'b001, 3'b000, 1'b1, 1'b0, 3'b100, {l2_hold(8'h83), 16'h0000});
    add_rec(c0 + 2, 3'b011, 3'b001, 1'b1, 1'b0, 3'b100, {l2_hold(8'h83), 16'h0000});
    add_rec(c0 + 3, 3'b111, 3'b011, 1'b1, 1'b0, 3'b100, {l2_hold(8'h83), 16'h0000});
    add_rec(c0 + 4, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 24'h000000);
    add_rec(c0 + 5, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000000);
    exp_d[0].push_back(8'h90); exp_d[0].push_back(8'h91); exp_d[0].push_back(8'h92);
    exp_d[1].push_back(8'hA0); exp_d[1].push_back(8'hA1);
    exp_d[2].push_back(8'hB0);
    load3(8'h90, 8'hA0, 8'hB0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    clear_fifos();
    load3(8'hC0, 8'hD0, 8'hE0);
    tick();
    c0 = cyc;
    push_tile(c0, 1'b0, l2_hold(8'hB0), 8'hC0, 8'hD0, 8'hE0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (8) tick();
    repeat (2) tick();

    // Asynchronous reset between edges in offset 3, then a normal tile.
    c0 = cyc;
    add_rec(c0 + 0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000000);
    add_rec(c0 + 1, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 24'h000000);
    add_rec(c0 + 2, 3'b011, 3'b001, 1'b1, 1'b0, 3'b000, 24'h000000);
    exp_d[0].push_back(8'h15);
    load3(8'h15, 8'h25, 8'h35);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();
    #1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    clear_fifos();
    tick();
    c0 = cyc;
    push_tile(c0, 1'b0, 8'h00, 8'h18, 8'h28, 8'h38);
    load3(8'h18, 8'h28, 8'h38);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (8) tick();
    repeat (2) tick();

    end_req = 1'b1;
    repeat (4) tick();
    $display("FAIL monitor_end cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "monitor did not end the run");
  end

endmodule
